// File: rtl/aim_rd_burst_issuer.sv
// aim_rd_burst_issuer: AXI4 read master, 4KB-safe credit-limited bursts.
// Optional perf counters under `define AIM_RD_PERF_CNT_EN.
module aim_rd_burst_issuer #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST      = 16,
  parameter int RD_DATA_DEPTH  = 64,
  parameter int BEATS_W        = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BEATS_W-1:0]        cmd_beats,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done,
  output logic                      err
`ifdef AIM_RD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_ar_stall,
  output logic [31:0]               perf_credit_stall
`endif
);

  localparam int PW = (RD_DATA_DEPTH > 1) ? $clog2(RD_DATA_DEPTH) : 1;
  localparam int CW = $clog2(RD_DATA_DEPTH + 1);
  localparam int OW = $clog2(RD_DATA_DEPTH + 257);
  localparam int LW = 9;
  localparam logic [LW-1:0] MAXB     = LW'(MAX_BURST);
  localparam logic [OW-1:0] DEPTH_O  = OW'(RD_DATA_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RD_DATA_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RD_DATA_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t state;

  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [BEATS_W-1:0]        to_issue;
  logic [BEATS_W-1:0]        to_pop;
  logic [OW-1:0]             outstanding;

  logic [LW-1:0] page_beats;
  logic [LW-1:0] rem_cap;
  logic [LW-1:0] len_c;
  logic [LW-1:0] issued_len;
  logic          credit_ok;
  logic          ar_hs;
  logic          push;
  logic          pop;
  logic          err_hit;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[4:0];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Next burst length: remaining, burst cap and 4KB page limit.
  always_comb begin
    page_beats = 9'd128 - {2'b00, addr[11:5]};
    rem_cap = MAXB;
    if (32'(to_issue) < 32'(MAX_BURST))
      rem_cap = LW'(to_issue);
    len_c = (rem_cap < page_beats) ? rem_cap : page_beats;
  end

  assign issued_len = {1'b0, m_axi_arlen} + LW'(1);
  assign credit_ok  = (outstanding + OW'(len_c)) <= DEPTH_O;
  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign push       = m_axi_rvalid && m_axi_rready;
  assign pop        = out_valid && out_ready;

  // Command FSM, AR channel and credit / beat bookkeeping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      addr          <= '0;
      to_issue      <= '0;
      to_pop        <= '0;
      outstanding   <= '0;
    end else begin
      done <= 1'b0;
      if (err_hit)
        err <= 1'b1;
      outstanding <= outstanding
                   + (ar_hs ? OW'(issued_len) : '0)
                   - OW'(pop);
      if (pop)
        to_pop <= to_pop - BEATS_W'(1);
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr      <= {cmd_addr[AXI_ADDR_WIDTH-1:5], 5'b0};
            to_issue  <= cmd_beats;
            to_pop    <= cmd_beats;
            err       <= 1'b0;
            state     <= (cmd_beats == '0) ? S_DONE : S_ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            addr     <= addr
                      + (AXI_ADDR_WIDTH'(issued_len) << 5);
            to_issue <= to_issue - BEATS_W'(issued_len);
            if (to_issue == BEATS_W'(issued_len))
              state <= S_DRAIN;
          end else if (!m_axi_arvalid && credit_ok) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(len_c - LW'(1));
          end
        end
        S_DRAIN: begin
          if (to_pop == '0)
            state <= S_DONE;
        end
        S_DONE: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat FIFO behind a registered output stage with empty bypass.
  logic [AXI_DATA_WIDTH-1:0] f_mem [RD_DATA_DEPTH];
  logic [PW-1:0]             f_wr;
  logic [PW-1:0]             f_rd;
  logic [CW-1:0]             f_cnt;
  logic [CW-1:0]             f_cnt_n;
  logic                      f_empty;
  logic                      out_free;
  logic                      f_push;
  logic                      f_pop;

  assign out_free = !out_valid || out_ready;
  assign f_empty  = (f_cnt == '0);
  assign f_pop    = out_free && !f_empty;
  assign f_push   = push && !(out_free && f_empty);
  assign f_cnt_n  = f_cnt + CW'(f_push) - CW'(f_pop);

  // Output stage load, FIFO pointers and R-channel backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      f_wr         <= '0;
      f_rd         <= '0;
      f_cnt        <= '0;
      m_axi_rready <= 1'b0;
    end else begin
      if (out_free) begin
        if (!f_empty) begin
          out_valid <= 1'b1;
          out_data  <= f_mem[f_rd];
        end else if (push) begin
          out_valid <= 1'b1;
          out_data  <= m_axi_rdata;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (f_push)
        f_wr <= nxt(f_wr);
      if (f_pop)
        f_rd <= nxt(f_rd);
      f_cnt        <= f_cnt_n;
      m_axi_rready <= (f_cnt_n != DEPTH_C);
    end
  end

  // Issued burst lengths, used to locate each burst's last beat.
  logic [LW-1:0] lq_mem [RD_DATA_DEPTH];
  logic [PW-1:0] lq_wr;
  logic [PW-1:0] lq_rd;
  logic [CW-1:0] lq_cnt;
  logic [LW-1:0] beat_cnt;
  logic          lq_empty;
  logic          last_exp;
  logic          lq_pop;

  assign lq_empty = (lq_cnt == '0);
  assign last_exp = !lq_empty
                 && ((beat_cnt + LW'(1)) == lq_mem[lq_rd]);
  assign lq_pop   = push && last_exp;
  assign err_hit  = push && ((m_axi_rresp != 2'b00)
                          || (m_axi_rlast != last_exp)
                          || lq_empty);

  // Storage arrays carry no reset; pointers define validity.
  always_ff @(posedge aclk) begin
    if (ar_hs)
      lq_mem[lq_wr] <= issued_len;
    if (f_push)
      f_mem[f_wr] <= m_axi_rdata;
  end

  // Per-burst beat counter against the length queue.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lq_wr    <= '0;
      lq_rd    <= '0;
      lq_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      if (ar_hs)
        lq_wr <= nxt(lq_wr);
      if (lq_pop)
        lq_rd <= nxt(lq_rd);
      lq_cnt <= lq_cnt + CW'(ar_hs) - CW'(lq_pop);
      if (push && !lq_empty)
        beat_cnt <= last_exp ? '0 : beat_cnt + LW'(1);
    end
  end

`ifdef AIM_RD_PERF_CNT_EN
  logic ar_stall;
  logic cr_stall;

  assign ar_stall = m_axi_arvalid && !m_axi_arready;
  assign cr_stall = (state == S_ISSUE)
                 && !m_axi_arvalid && !credit_ok;

  // Stall counters restart per command and saturate.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_ar_stall     <= '0;
      perf_credit_stall <= '0;
    end else if (cmd_valid && cmd_ready) begin
      perf_ar_stall     <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (ar_stall && (perf_ar_stall != '1))
        perf_ar_stall <= perf_ar_stall + 32'd1;
      if (cr_stall && (perf_credit_stall != '1))
        perf_credit_stall <= perf_credit_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aim_rd_burst_issuer.sv
// tb_aim_rd_burst_issuer: random AXI slave plus burst-split and
// in-order stream reference model for aim_rd_burst_issuer.
module tb_aim_rd_burst_issuer;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int DEPTH = 64;

  typedef struct {
    logic [AW-1:0] a;
    int            n;
  } burst_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [15:0]   cmd_beats = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          done;
  logic          err;

  aim_rd_burst_issuer dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
    .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  // knobs
  int ready_mode = 0;
  bit ar_rand = 0;
  bit r_rand = 0;
  int err_beat = -1;
  int bad_last = -1;
  bit exp_err = 0;

  // model state
  burst_t exp_ar[$];
  burst_t ar_log[$];
  burst_t sq[$];
  logic [AW-1:0] exp_bt[$];
  int  issued = 0, popped = 0, cur_n = 0, done_cnt = 0;
  int  rcyc = 0, rbeat = 0, sb = 0;
  bit  busy = 0, r_fire = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;

  function automatic void chk(input string nm,
                              input logic [DW-1:0] act,
                              input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endfunction

  function automatic void fail(input string nm,
                               input string act,
                               input string req);
    total++;
    bad++;
    $display("FAIL %s act=%s req=%s", nm, act, req);
  endfunction

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++)
      d[i*32 +: 32] = a ^ (32'h9E3779B9 * 32'(i + 1));
    return d;
  endfunction

  // Reference split: each burst is min(remaining, 16, beats to 4KB).
  function automatic void plan(input logic [AW-1:0] a0, input int n);
    logic [AW-1:0] a;
    int rem;
    a = {a0[AW-1:5], 5'b0};
    rem = n;
    exp_ar.delete();
    exp_bt.delete();
    while (rem > 0) begin
      int page;
      int l;
      page = (4096 - int'(a[11:0])) / 32;
      l = rem;
      if (l > MB) l = MB;
      if (l > page) l = page;
      exp_ar.push_back('{a, l});
      for (int k = 0; k < l; k++)
        exp_bt.push_back(a + 32'(k * 32));
      a = a + 32'(l * 32);
      rem -= l;
    end
  endfunction

  // Compare process: every cycle at the falling edge.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_ar.delete();
        exp_bt.delete();
        busy = 0;
        issued = 0;
        popped = 0;
        rcyc = 0;
        prev_stall = 0;
      end else begin
        rcyc++;
        if (cmd_valid && cmd_ready) begin
          plan(cmd_addr, int'(cmd_beats));
          cur_n = int'(cmd_beats);
          issued = 0;
          popped = 0;
          rbeat = 0;
          busy = 1;
        end
        if (prev_stall)
          chk("ar_hold", {arvalid, arlen, araddr},
              {1'b1, prev_len, prev_addr});
        prev_stall = arvalid && !arready;
        prev_addr = araddr;
        prev_len = arlen;
        if (arvalid && arready) begin
          ar_log.push_back('{araddr, int'(arlen) + 1});
          sq.push_back('{araddr, int'(arlen) + 1});
          if (exp_ar.size() == 0) begin
            fail("ar_extra", "burst", "none");
          end else begin
            burst_t e;
            e = exp_ar.pop_front();
            chk("ar_addr", araddr, e.a);
            chk("ar_len", arlen, 8'(e.n - 1));
          end
          issued += int'(arlen) + 1;
          chk("credit", (issued - popped) <= DEPTH, 1'b1);
        end
        if (rvalid && rready)
          r_fire = 1;
        if (out_valid) begin
          if (exp_bt.size() == 0)
            fail("out_extra", "valid", "idle");
          else if (out_ready) begin
            chk("out_data", out_data, pat(exp_bt.pop_front()));
            popped++;
          end
        end
        if (rcyc >= 2)
          chk("rready", rready, 1'b1);
        if (done) begin
          if (!busy) begin
            fail("done_spurious", "1", "0");
          end else begin
            chk("done_beats", popped, cur_n);
            chk("done_ar_left", exp_ar.size(), 0);
            chk("done_err", err, exp_err);
            busy = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  // AXI slave and stream sink, driven just after the rising edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        sq.delete();
        sb = 0;
        r_fire = 0;
        rvalid = 0;
        rlast = 0;
        rresp = 0;
        arready = 0;
      end else begin
        arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (ready_mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(0, 1) == 1);
          default: out_ready = 1'b0;
        endcase
        if (r_fire) begin
          r_fire = 0;
          rvalid = 0;
          sb++;
          rbeat++;
          if (sq.size() != 0 && sb == sq[0].n) begin
            void'(sq.pop_front());
            sb = 0;
          end
        end
        if (!rvalid && sq.size() != 0 &&
            (!r_rand || $urandom_range(0, 2) != 0)) begin
          rvalid = 1;
          rdata = pat(sq[0].a + 32'(sb * 32));
          rlast = (sb == sq[0].n - 1);
          if (rbeat == bad_last) rlast = !rlast;
          rresp = (rbeat == err_beat) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input int n);
    int t;
    @(posedge aclk);
    #1;
    cmd_addr = a;
    cmd_beats = 16'(n);
    cmd_valid = 1;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!cmd_ready && t < 200);
    if (!cmd_ready) fail("cmd_timeout", "no_ready", "ready");
    @(posedge aclk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (busy && t < lim) begin
      @(negedge aclk);
      t++;
    end
    if (busy) fail("done_timeout", "busy", "done");
    @(negedge aclk);
  endtask

  task automatic chk_ar(input string nm, input int i,
                        input logic [AW-1:0] a, input int len);
    if (i >= ar_log.size()) begin
      fail(nm, "missing", "burst");
    end else begin
      chk(nm, {ar_log[i].a, 8'(ar_log[i].n - 1)}, {a, 8'(len)});
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #1 aresetn = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_rready", rready, 0);
    chk("rst_out", {out_valid, out_data}, 0);
    chk("rst_done_err", {done, err}, 0);
    @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk);
    @(negedge aclk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // 40 beats from 0x1000
    ar_log.delete();
    d0 = done_cnt;
    send_cmd(32'h0000_1000, 40);
    wait_done(3000);
    chk("t1_nar", ar_log.size(), 3);
    chk_ar("t1_ar0", 0, 32'h1000, 15);
    chk_ar("t1_ar1", 1, 32'h1200, 15);
    chk_ar("t1_ar2", 2, 32'h1400, 7);
    chk("t1_ndone", done_cnt - d0, 1);
    chk("t1_err", err, 0);

    // 4KB boundary split
    ar_log.delete();
    ar_rand = 1;
    r_rand = 1;
    send_cmd(32'h0000_0F80, 10);
    wait_done(3000);
    chk("t2_nar", ar_log.size(), 2);
    chk_ar("t2_ar0", 0, 32'h0F80, 3);
    chk_ar("t2_ar1", 1, 32'h1000, 5);

    // credit stall with sink blocked
    ar_log.delete();
    ar_rand = 0;
    r_rand = 0;
    ready_mode = 2;
    send_cmd(32'h0000_4000, 128);
    repeat (300) @(negedge aclk);
    chk("t3_nar_stall", ar_log.size(), 4);
    chk("t3_arvalid", arvalid, 0);
    chk("t3_rready", rready, 1);
    chk("t3_out_valid", out_valid, 1);
    ready_mode = 0;
    wait_done(5000);
    chk("t3_nar_end", ar_log.size(), 8);
    chk("t3_popped", popped, 128);

    // bad response on one beat
    err_beat = 5;
    exp_err = 1;
    send_cmd(32'h0000_0200, 16);
    wait_done(3000);
    chk("t4_err", err, 1);
    chk("t4_popped", popped, 16);
    err_beat = -1;
    exp_err = 0;

    // zero beats; accept also clears err
    ar_log.delete();
    send_cmd(32'h0000_0300, 0);
    @(negedge aclk);
    chk("t5_err_clr", err, 0);
    chk("t5_done_early", done, 0);
    @(negedge aclk);
    chk("t5_done", done, 1);
    wait_done(50);
    chk("t5_nar", ar_log.size(), 0);

    // random commands, one with a misplaced rlast
    for (int it = 0; it < 10; it++) begin
      ar_rand = $urandom_range(0, 1) == 1;
      r_rand = $urandom_range(0, 1) == 1;
      ready_mode = int'($urandom_range(0, 1));
      bad_last = (it == 3) ? 0 : -1;
      exp_err = (it == 3);
      send_cmd($urandom() & 32'h0000_FFFF,
               int'($urandom_range(1, 150)));
      wait_done(20000);
    end
    bad_last = -1;
    exp_err = 0;
    ar_rand = 0;
    r_rand = 0;

    // reset while draining
    ready_mode = 2;
    send_cmd(32'h0000_2000, 32);
    repeat (80) @(negedge aclk);
    chk("t7_pre_valid", out_valid, 1);
    @(posedge aclk);
    #2 aresetn = 0;
    #1;
    chk("t7_rst_out_valid", out_valid, 0);
    chk("t7_rst_done", done, 0);
    chk("t7_rst_arvalid", arvalid, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    ready_mode = 0;
    @(posedge aclk);
    @(negedge aclk);
    chk("t7_cmd_ready", cmd_ready, 1);
    send_cmd(32'h0000_0000, 20);
    wait_done(3000);
    chk("t7_after_popped", popped, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aim_rd_burst_issuer.md
Name: aim_rd_burst_issuer

Overview:
- AXI4 read master that sits directly upstream of the AiM subsystem top and drives its s_axi_ar*/s_axi_r* slave port.
- Accepts a single host read command (base address plus total beat count) and splits it into legal INCR bursts.
- Credit-limits the bursts so that every returned beat fits in a local FIFO.
- Delivers the data as an in-order valid/ready stream and ends each command with a done pulse and a sticky error flag.

Parameters:
AXI_DATA_WIDTH, 256, data bus width; one beat = 32 B
AXI_ADDR_WIDTH, 32, address width
MAX_BURST, 16, maximum beats per AR burst (1..256)
RD_DATA_DEPTH, 64, local FIFO depth in beats; must be >= MAX_BURST
BEATS_W, 16, width of cmd_beats

Ports:
aclk  in  1  single clock for the block
aresetn  in  1  reset, asynchronous assert, active-low
cmd_addr  in  AXI_ADDR_WIDTH  start byte address; bits [4:0] ignored and forced 0
cmd_beats  in  BEATS_W  total beats to read
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
m_axi_araddr  out  AXI_ADDR_WIDTH  burst address
m_axi_arlen  out  8  burst length minus 1
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  AXI_DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
out_data  out  AXI_DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
done  out  1  one-cycle pulse: command complete
err  out  1  sticky error for the current/last command

Behaviour:
- Reset values (async on aresetn low): cmd_ready=0, m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0, m_axi_rready=0, out_valid=0, out_data=0, done=0, err=0; FIFO and all counters cleared. First cycle after release: IDLE with cmd_ready=1.
- Integration ties for the subsystem's other AR inputs: arid=0, arsize=3'b101, arburst=INCR, all others 0.
- FSM:
  - IDLE: cmd_ready=1. On accept, latch addr/beats, clear err. beats=0 -> DONE; else -> ISSUE.
  - ISSUE: len=min(remaining_to_issue, MAX_BURST, (4096-addr[11:0])/32). Raise arvalid when credit allows: outstanding+len <= RD_DATA_DEPTH, where outstanding = beats issued but not yet popped from out. araddr/arlen held stable while arvalid&!arready. On handshake: addr+=len*32, remaining-=len, outstanding+=len. Remaining reaches 0 -> DRAIN.
  - DRAIN: wait until all command beats are popped from out -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. cmd_ready=0 in all states except IDLE.
- R path:
  - m_axi_rready = !fifo_full; credit guarantees it never deasserts in legal operation.
  - Beat pushed on rvalid&rready; out_data/out_valid reflect it the next cycle (1-cycle latency).
  - Push and pop in the same cycle leave the count unchanged, including when full.
- Errors (err set, sticky until next command accept; data still forwarded, beat counts unaffected):
  - rresp != 0;
  - rlast on a beat that is not the last of its burst;
  - rlast missing on the last beat of a burst.
- Per-burst beat counter is checked against a small FIFO of issued lengths (depth RD_DATA_DEPTH/1 bursts max, MAX_BURST>=1).
- Reset mid-operation discards FIFO contents, in-flight counts and FSM state. The subsystem shares aresetn, so no stale R beats arrive.

Optional Feature:
- AIM_RD_PERF_CNT_EN defined: adds output perf_ar_stall (32 bits), which counts cycles with m_axi_arvalid&!m_axi_arready, and output perf_credit_stall (32 bits), which counts ISSUE cycles blocked by credit. Both clear on command accept, saturate at all-ones, and reset to 0.
- Undefined: neither port nor either counter exists.

Test Plan:
- cmd_addr=0x0000_1000, beats=40, out_ready=1 -> AR (0x1000,len 15), (0x1200,15), (0x1400,7); 40 beats in order; single done; err=0.
- cmd_addr=0x0000_0F80, beats=10 -> AR (0x0F80,arlen 3), (0x1000,arlen 5); no burst crosses 4 KB.
- beats=128, out_ready=0 -> exactly 4 bursts (64 beats) issued, then arvalid stays 0 and rready stays 1; release out_ready -> remaining 4 bursts issued, 128 beats out, no overflow.
- rresp=2'b10 on beat 5 of beats=16 -> all 16 beats delivered, err=1 at done; next command accept clears err.
- beats=0 -> done pulses 2 cycles after accept, arvalid never asserted.
- aresetn low mid-DRAIN with out_valid=1 -> out_valid, done, arvalid go 0 immediately; cmd_ready=1 one cycle after release.
